score_event_encoder: RTL and testbench

Producer side of the score-pulse interface that feeds the BCD score display counter. It accepts a WIDTH-bit "destroyed objects" vector from game logic through a valid/ready handshake and counts the set bits. It then emits one clean score pulse per destroyed object, each pulse high for exactly one cycle and followed by a guaranteed low gap, so the edge-triggered display counter increments once per object.

---
 rtl/score_event_encoder.sv | 104 ++++++++++
 tb/tb_score_event_encoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/score_event_encoder.sv
// Score-pulse producer: counts set bits of accepted destroy vectors and emits one
// gapped single-cycle pulse per object. Optional combo bonus under SCORE_EVT_BONUS_EN.
module score_event_encoder #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] des_in,
  input  logic             des_valid,
  output logic             des_ready,
  output logic [WIDTH-1:0] score_des,
  output logic             score_pulse,
  output logic [CNT_W-1:0] pending,
  output logic             busy
);

`ifdef SCORE_EVT_BONUS_EN
  localparam int unsigned BONUS_MAX = 2;
`else
  localparam int unsigned BONUS_MAX = 0;
`endif
  localparam int unsigned GAP_W     = $clog2(GAP + 1);
  localparam int unsigned POP_W     = $clog2(WIDTH + 1);
  localparam int unsigned READY_MAX = (1 << CNT_W) - 1 - WIDTH - BONUS_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [POP_W-1:0]   pop;
  logic [CNT_W-1:0]   add;
  logic [CNT_W-1:0]   pending_d;
  logic               accept;
  logic               enter_high;

  // Popcount of the offered vector, plus the combo bonus when enabled
  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop = pop + POP_W'(des_in[i]);
    end
    add = CNT_W'(pop);
`ifdef SCORE_EVT_BONUS_EN
    if (pop >= POP_W'(3)) begin
      add = add + CNT_W'(2);
    end
`endif
  end

  // Threshold leaves headroom for a full vector plus bonus, so pending never wraps
  assign des_ready = (pending <= CNT_W'(READY_MAX));
  assign accept    = des_valid & des_ready;
  assign busy      = (state_q != IDLE) || (pending != '0);
  assign score_des = {{(WIDTH-1){1'b0}}, score_pulse};

  // Next-state logic: IDLE -> HIGH (one cycle) -> LOW (GAP cycles) -> IDLE
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    enter_high = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending != '0) begin
          enter_high = 1'b1;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        gap_d   = GAP_W'(GAP);
        state_d = LOW;
      end
      LOW: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = pending + (accept ? add : '0) - CNT_W'(enter_high);
  end

  // Pulse is a flop tracking the HIGH state so it is glitch-free downstream
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      pending     <= '0;
      score_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      pending     <= pending_d;
      score_pulse <= (state_d == HIGH);
    end
  end

endmodule

// File: tb/tb_score_event_encoder.sv
// Directed self-checking bench for score_event_encoder (WIDTH=10, GAP=1, CNT_W=8).
module tb_score_event_encoder;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] des_in;
  logic       des_valid;
  logic       des_ready;
  logic [9:0] score_des;
  logic       score_pulse;
  logic [7:0] pending;
  logic       busy;

  int total = 0;
  int bad   = 0;

  score_event_encoder #(.WIDTH(10), .GAP(1), .CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .des_in     (des_in),
    .des_valid  (des_valid),
    .des_ready  (des_ready),
    .score_des  (score_des),
    .score_pulse(score_pulse),
    .pending    (pending),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    int p;
    reset = 1'b1; des_valid = 1'b1; des_in = 10'h3FF;
    tick; tick;
    total++; if (pending !== 8'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    total++; if (score_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", score_pulse); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (des_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", des_ready); end
    total++; if (score_des !== 10'h000) begin bad++; $display("FAIL reset_score_des got=%h exp=000", score_des); end
    reset = 1'b0; des_valid = 1'b0; des_in = '0;
    p = 0;
    repeat (6) begin tick; if (score_pulse) p++; end
    total++; if (p !== 0) begin bad++; $display("FAIL reset_no_pulses got=%0d exp=0", p); end
  endtask

  task automatic test_single;
    logic exp;
    des_in = 10'b0000010101; des_valid = 1'b1;
    tick;
    des_valid = 1'b0; des_in = '0;
    total++; if (pending !== 8'd3) begin bad++; $display("FAIL single_pending got=%0d exp=3", pending); end
    total++; if (score_pulse !== 1'b0) begin bad++; $display("FAIL single_pulse_k got=%b exp=0", score_pulse); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_k got=%b exp=1", busy); end
    for (int i = 1; i <= 10; i++) begin
      tick;
      exp = (i == 1) || (i == 4) || (i == 7);
      total++;
      if (score_pulse !== exp) begin bad++; $display("FAIL single_pulse_k+%0d got=%b exp=%b", i, score_pulse, exp); end
      if (i == 1) begin
        total++; if (score_des !== 10'h001) begin bad++; $display("FAIL single_score_des got=%h exp=001", score_des); end
      end
      if (i == 7) begin
        total++; if (pending !== 8'd0) begin bad++; $display("FAIL single_pending_end got=%0d exp=0", pending); end
      end
      if (i == 8) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_k+8 got=%b exp=1", busy); end
      end
      if (i == 9) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_k+9 got=%b exp=0", busy); end
      end
    end
  endtask

  task automatic test_overlap;
    int p;
    des_in = 10'b1; des_valid = 1'b1;
    tick;
    total++; if (pending !== 8'd1) begin bad++; $display("FAIL overlap_pre got=%0d exp=1", pending); end
    des_in = 10'b11;
    tick;
    des_valid = 1'b0; des_in = '0;
    total++; if (pending !== 8'd2) begin bad++; $display("FAIL overlap_net got=%0d exp=2", pending); end
    total++; if (score_pulse !== 1'b1) begin bad++; $display("FAIL overlap_high got=%b exp=1", score_pulse); end
    p = 1;
    repeat (12) begin tick; if (score_pulse) p++; end
    total++; if (p !== 3) begin bad++; $display("FAIL overlap_count got=%0d exp=3", p); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL overlap_busy got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure;
    reset = 1'b1; tick; reset = 1'b0;
    des_in = 10'h3FF; des_valid = 1'b1;
    repeat (24) tick;
    total++; if (pending !== 8'd232) begin bad++; $display("FAIL bp_build got=%0d exp=232", pending); end
    tick;
    des_in = 10'h01F;
    tick;
    des_in = 10'h3FF;
    total++; if (pending !== 8'd246) begin bad++; $display("FAIL bp_246 got=%0d exp=246", pending); end
    total++; if (des_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_246 got=%b exp=0", des_ready); end
    tick;
    total++; if (pending !== 8'd246) begin bad++; $display("FAIL bp_hold1 got=%0d exp=246", pending); end
    tick;
    total++; if (pending !== 8'd246) begin bad++; $display("FAIL bp_hold2 got=%0d exp=246", pending); end
    tick;
    total++; if (pending !== 8'd245) begin bad++; $display("FAIL bp_245 got=%0d exp=245", pending); end
    total++; if (des_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_245 got=%b exp=1", des_ready); end
    tick;
    total++; if (pending !== 8'd255) begin bad++; $display("FAIL bp_255 got=%0d exp=255", pending); end
    total++; if (des_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_255 got=%b exp=0", des_ready); end
    des_valid = 1'b0; des_in = '0;
  endtask

  task automatic test_reset_mid;
    int p;
    reset = 1'b1; tick; reset = 1'b0;
    des_in = 10'h03F; des_valid = 1'b1;
    tick;
    des_valid = 1'b0; des_in = '0;
    tick;
    total++; if (score_pulse !== 1'b1 || pending !== 8'd5) begin
      bad++; $display("FAIL mid_setup got pulse=%b pending=%0d exp pulse=1 pending=5", score_pulse, pending);
    end
    reset = 1'b1; des_valid = 1'b1; des_in = 10'h3FF;
    tick;
    reset = 1'b0; des_valid = 1'b0; des_in = '0;
    total++; if (score_pulse !== 1'b0) begin bad++; $display("FAIL mid_pulse got=%b exp=0", score_pulse); end
    total++; if (pending !== 8'd0) begin bad++; $display("FAIL mid_pending got=%0d exp=0", pending); end
    p = 0;
    repeat (10) begin tick; if (score_pulse) p++; end
    total++; if (p !== 0) begin bad++; $display("FAIL mid_no_pulses got=%0d exp=0", p); end
  endtask

  task automatic test_combo;
    int p;
    int exp_big;
`ifdef SCORE_EVT_BONUS_EN
    exp_big = 5;
`else
    exp_big = 3;
`endif
    des_in = 10'h000; des_valid = 1'b1;
    tick;
    total++; if (pending !== 8'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_vec got pending=%0d busy=%b exp 0 0", pending, busy);
    end
    des_in = 10'b0000000111;
    tick;
    des_valid = 1'b0; des_in = '0;
    total++; if (pending !== 8'(exp_big)) begin bad++; $display("FAIL combo_pending got=%0d exp=%0d", pending, exp_big); end
    p = 0;
    repeat (20) begin tick; if (score_pulse) p++; end
    total++; if (p !== exp_big) begin bad++; $display("FAIL combo_count got=%0d exp=%0d", p, exp_big); end
    des_in = 10'b11; des_valid = 1'b1;
    tick;
    des_valid = 1'b0; des_in = '0;
    p = 0;
    repeat (12) begin tick; if (score_pulse) p++; end
    total++; if (p !== 2) begin bad++; $display("FAIL pair_count got=%0d exp=2", p); end
  endtask

  initial begin
    reset = 1'b1; des_valid = 1'b0; des_in = '0;
    test_reset;
    test_single;
    test_overlap;
    test_backpressure;
    test_reset_mid;
    test_combo;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
